// File: rtl/obi2axi_lite_pkg.sv
// Shared types and constants for the OBI -> AXI4-Lite master bridge.
// Contents:
//   state_e        - bridge FSM states
//   AXI_RESP_OKAY  - AXI response code treated as success
//   obi_req_t      - OBI request bundle (kept for later reuse)
//   obi_resp_t     - OBI response bundle (kept for later reuse)
package obi2axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_RESP
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

endpackage

// File: rtl/obi2axi_lite_if.sv
// Bus interfaces of the OBI -> AXI4-Lite bridge.
//   obi_if      - OBI data port. master = core side, slave = bridge side.
//                 req/addr/we/be/wdata flow to the slave; gnt/rvalid/rdata/err flow back.
//   axi_lite_if - AXI4-Lite link. master = bridge side, slave = link endpoint.
//                 AW/W/AR valid+payload and B/R ready come from the master.
interface obi_if #(
  parameter int AddrWidth = 32
);
  logic                 data_req_i;
  logic                 data_gnt_o;
  logic [AddrWidth-1:0] data_addr_i;
  logic                 data_we_i;
  logic [3:0]           data_be_i;
  logic [31:0]          data_wdata_i;
  logic                 data_rvalid_o;
  logic [31:0]          data_rdata_o;
  logic                 data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

interface axi_lite_if #(
  parameter int AddrWidth = 32
);
  logic [AddrWidth-1:0] m00_axi_awaddr;
  logic [2:0]           m00_axi_awprot;
  logic                 m00_axi_awvalid;
  logic                 m00_axi_awready;
  logic [31:0]          m00_axi_wdata;
  logic [3:0]           m00_axi_wstrb;
  logic                 m00_axi_wvalid;
  logic                 m00_axi_wready;
  logic [1:0]           m00_axi_bresp;
  logic                 m00_axi_bvalid;
  logic                 m00_axi_bready;
  logic [AddrWidth-1:0] m00_axi_araddr;
  logic [2:0]           m00_axi_arprot;
  logic                 m00_axi_arvalid;
  logic                 m00_axi_arready;
  logic [31:0]          m00_axi_rdata;
  logic [1:0]           m00_axi_rresp;
  logic                 m00_axi_rvalid;
  logic                 m00_axi_rready;

  modport master (
    output m00_axi_awaddr, m00_axi_awprot, m00_axi_awvalid,
    input  m00_axi_awready,
    output m00_axi_wdata, m00_axi_wstrb, m00_axi_wvalid,
    input  m00_axi_wready,
    input  m00_axi_bresp, m00_axi_bvalid,
    output m00_axi_bready,
    output m00_axi_araddr, m00_axi_arprot, m00_axi_arvalid,
    input  m00_axi_arready,
    input  m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid,
    output m00_axi_rready
  );

  modport slave (
    input  m00_axi_awaddr, m00_axi_awprot, m00_axi_awvalid,
    output m00_axi_awready,
    input  m00_axi_wdata, m00_axi_wstrb, m00_axi_wvalid,
    output m00_axi_wready,
    output m00_axi_bresp, m00_axi_bvalid,
    input  m00_axi_bready,
    input  m00_axi_araddr, m00_axi_arprot, m00_axi_arvalid,
    output m00_axi_arready,
    output m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid,
    input  m00_axi_rready
  );
endinterface

// File: rtl/obi2axi_wr_tracker.sv
// Tracks the AW and W channels of one AXI-Lite write independently.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   active     - bridge is in its AW+W phase
//   awready    - AXI AW ready from the slave
//   wready     - AXI W ready from the slave
//   awvalid    - AXI AW valid (held until its own handshake)
//   wvalid     - AXI W valid (held until its own handshake)
//   done       - both channels have handshaken (possibly this cycle)
module obi2axi_wr_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic done
);

  logic aw_done_q;
  logic w_done_q;
  logic aw_hs;
  logic w_hs;

  // Valids depend only on registered state, never on the ready inputs.
  assign awvalid = active & ~aw_done_q;
  assign wvalid  = active & ~w_done_q;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign done    = active & (aw_done_q | aw_hs) & (w_done_q | w_hs);

  // Flags are sticky per channel and cleared together when the phase ends,
  // so they are already clear for the next write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (done) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/obi2axi_lite.sv
// OBI slave -> AXI4-Lite master bridge, single outstanding transaction, 32-bit data.
// Ports:
//   m00_axi_aclk    - clock
//   m00_axi_aresetn - async active-low reset
//   obi             - OBI data port (slave side)
//   axi             - AXI4-Lite link (master side)
// Parameters:
//   AddrWidth - OBI/AXI address width
//   DataWidth - must be 32
//   AxProt    - constant driven on awprot/arprot
module obi2axi_lite
  import obi2axi_pkg::*;
#(
  parameter int         AddrWidth = 32,
  parameter int         DataWidth = 32,
  parameter logic [2:0] AxProt    = 3'b000
) (
  input  logic            m00_axi_aclk,
  input  logic            m00_axi_aresetn,
  obi_if.slave            obi,
  axi_lite_if.master      axi
);

  if (DataWidth != 32) begin : g_bad_width
    $error("obi2axi_lite: only DataWidth=32 is supported");
  end

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           be_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic                 wr_done;
  logic                 accept;

  // A request is accepted only while idle; gnt simply mirrors req there.
  assign accept = (state_q == ST_IDLE) & obi.data_req_i;

  obi2axi_wr_tracker u_wr_tracker (
    .clk     (m00_axi_aclk),
    .rst_n   (m00_axi_aresetn),
    .active  (state_q == ST_WR),
    .awready (axi.m00_axi_awready),
    .wready  (axi.m00_axi_wready),
    .awvalid (axi.m00_axi_awvalid),
    .wvalid  (axi.m00_axi_wvalid),
    .done    (wr_done)
  );

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (obi.data_req_i) state_d = obi.data_we_i ? ST_WR : ST_RD_AR;
      ST_WR:    if (wr_done) state_d = ST_WR_B;
      ST_WR_B:  if (axi.m00_axi_bvalid) state_d = ST_RESP;
      ST_RD_AR: if (axi.m00_axi_arready) state_d = ST_RD_R;
      ST_RD_R:  if (axi.m00_axi_rvalid) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request attributes are captured at grant; the response is captured
  // when the B or R beat is accepted. Writes return zero read data.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= obi.data_addr_i;
        be_q    <= obi.data_be_i;
        wdata_q <= obi.data_wdata_i;
      end
      if ((state_q == ST_WR_B) && axi.m00_axi_bvalid) begin
        rdata_q <= '0;
        err_q   <= (axi.m00_axi_bresp != AXI_RESP_OKAY);
      end
      if ((state_q == ST_RD_R) && axi.m00_axi_rvalid) begin
        rdata_q <= axi.m00_axi_rdata;
        err_q   <= (axi.m00_axi_rresp != AXI_RESP_OKAY);
      end
    end
  end

  assign obi.data_gnt_o    = accept;
  assign obi.data_rvalid_o = (state_q == ST_RESP);
  assign obi.data_rdata_o  = (state_q == ST_RESP) ? rdata_q : '0;
  assign obi.data_err_o    = (state_q == ST_RESP) & err_q;

  assign axi.m00_axi_awaddr  = addr_q;
  assign axi.m00_axi_awprot  = AxProt;
  assign axi.m00_axi_wdata   = wdata_q;
  assign axi.m00_axi_wstrb   = be_q;
  assign axi.m00_axi_bready  = (state_q == ST_WR_B);
  assign axi.m00_axi_araddr  = addr_q;
  assign axi.m00_axi_arprot  = AxProt;
  assign axi.m00_axi_arvalid = (state_q == ST_RD_AR);
  assign axi.m00_axi_rready  = (state_q == ST_RD_R);

endmodule

// File: tb/tb_obi2axi_lite.sv
// Self-checking bench for obi2axi_lite: OBI master and AXI-Lite slave are
// driven cycle by cycle; expected OBI responses are queued at grant time and
// compared by a monitor when data_rvalid_o appears.
module tb_obi2axi_lite;

  logic clk;
  logic rst_n;

  obi_if      #(.AddrWidth(32)) obi ();
  axi_lite_if #(.AddrWidth(32)) axi ();

  obi2axi_lite #(
    .AddrWidth (32),
    .DataWidth (32),
    .AxProt    (3'b000)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (rst_n),
    .obi             (obi),
    .axi             (axi)
  );

  int checkCount = 0;
  int failCount  = 0;

  logic [32:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every OBI response and checks
  // that response fields are zero while no response is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (obi.data_rvalid_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rvalid", 64'd1, 64'd0);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          checkOutput("rdata", 64'(obi.data_rdata_o), 64'(e[31:0]));
          checkOutput("err", 64'(obi.data_err_o), 64'(e[32]));
        end
      end else begin
        checkOutput("idle_rdata_err", {31'd0, obi.data_err_o, obi.data_rdata_o}, 64'd0);
      end
    end
  end

  // Presents an OBI request, waits (bounded) for grant, queues the expected
  // response, and returns one cycle after the grant with req dropped.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input logic expErr);
    int waited;
    obi.data_req_i   = 1'b1;
    obi.data_addr_i  = addr;
    obi.data_we_i    = we;
    obi.data_be_i    = be;
    obi.data_wdata_i = wdata;
    #1;
    waited = 0;
    while (!obi.data_gnt_o && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("gnt_seen", 64'(obi.data_gnt_o), 64'd1);
    sb.push_back({expErr, expRdata});
    tick();
    obi.data_req_i = 1'b0;
  endtask

  // Zero-wait AR, then R after rDelay idle cycles. Entered in the RD_AR cycle.
  task automatic finishRead(input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [1:0] rresp, input int rDelay);
    axi.m00_axi_arready = 1'b1;
    #1;
    checkOutput("arvalid", 64'(axi.m00_axi_arvalid), 64'd1);
    checkOutput("araddr", 64'(axi.m00_axi_araddr), 64'(addr));
    tick();
    axi.m00_axi_arready = 1'b0;
    checkOutput("rready", 64'(axi.m00_axi_rready), 64'd1);
    checkOutput("arvalid_drop", 64'(axi.m00_axi_arvalid), 64'd0);
    repeat (rDelay) tick();
    axi.m00_axi_rvalid = 1'b1;
    axi.m00_axi_rdata  = rdata;
    axi.m00_axi_rresp  = rresp;
    tick();
    axi.m00_axi_rvalid = 1'b0;
    axi.m00_axi_rdata  = '0;
    axi.m00_axi_rresp  = '0;
    checkOutput("rd_rvalid_o", 64'(obi.data_rvalid_o), 64'd1);
    checkOutput("rready_drop", 64'(axi.m00_axi_rready), 64'd0);
    tick();
    checkOutput("rd_resp_one_cycle", 64'(obi.data_rvalid_o), 64'd0);
  endtask

  // Zero-wait AW+W then B. Entered in the WR cycle.
  task automatic finishWrite(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [1:0] bresp);
    axi.m00_axi_awready = 1'b1;
    axi.m00_axi_wready  = 1'b1;
    #1;
    checkOutput("aw_w_valid", {62'd0, axi.m00_axi_awvalid, axi.m00_axi_wvalid}, 64'd3);
    checkOutput("awaddr", 64'(axi.m00_axi_awaddr), 64'(addr));
    checkOutput("wdata", 64'(axi.m00_axi_wdata), 64'(wdata));
    checkOutput("wstrb", 64'(axi.m00_axi_wstrb), 64'(be));
    tick();
    axi.m00_axi_awready = 1'b0;
    axi.m00_axi_wready  = 1'b0;
    checkOutput("bready", 64'(axi.m00_axi_bready), 64'd1);
    checkOutput("aw_w_drop", {62'd0, axi.m00_axi_awvalid, axi.m00_axi_wvalid}, 64'd0);
    axi.m00_axi_bvalid = 1'b1;
    axi.m00_axi_bresp  = bresp;
    tick();
    axi.m00_axi_bvalid = 1'b0;
    axi.m00_axi_bresp  = '0;
    checkOutput("wr_rvalid_o", 64'(obi.data_rvalid_o), 64'd1);
    checkOutput("bready_drop", 64'(axi.m00_axi_bready), 64'd0);
    tick();
  endtask

  initial begin
    obi.data_req_i      = 1'b0;
    obi.data_addr_i     = '0;
    obi.data_we_i       = 1'b0;
    obi.data_be_i       = '0;
    obi.data_wdata_i    = '0;
    axi.m00_axi_awready = 1'b0;
    axi.m00_axi_wready  = 1'b0;
    axi.m00_axi_bresp   = '0;
    axi.m00_axi_bvalid  = 1'b0;
    axi.m00_axi_arready = 1'b0;
    axi.m00_axi_rdata   = '0;
    axi.m00_axi_rresp   = '0;
    axi.m00_axi_rvalid  = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state.
    checkOutput("rst_valids", {58'd0, axi.m00_axi_awvalid, axi.m00_axi_wvalid,
                axi.m00_axi_arvalid, axi.m00_axi_bready, axi.m00_axi_rready,
                obi.data_rvalid_o}, 64'd0);
    checkOutput("rst_regs", {axi.m00_axi_awaddr, axi.m00_axi_wdata}, 64'd0);
    checkOutput("rst_wstrb", 64'(axi.m00_axi_wstrb), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero-wait read: grant at cycle 0, AR at 1, R at 2, response at 3.
    $display("[TB] read zero-wait");
    applyStimulus(32'h0000_1000, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);
    finishRead(32'h0000_1000, 32'hCAFE_F00D, 2'b00, 0);

    // Write with W accepted at cycle 1 and AW held until cycle 4.
    $display("[TB] write W before AW");
    axi.m00_axi_wready = 1'b1;
    applyStimulus(32'h0000_0020, 1'b1, 4'h3, 32'h1234_5678, 32'h0, 1'b0);
    checkOutput("c1_valids", {62'd0, axi.m00_axi_awvalid, axi.m00_axi_wvalid}, 64'd3);
    checkOutput("c1_wstrb", 64'(axi.m00_axi_wstrb), 64'h3);
    checkOutput("c1_awaddr", 64'(axi.m00_axi_awaddr), 64'h20);
    tick();
    axi.m00_axi_wready = 1'b0;
    checkOutput("c2_valids", {62'd0, axi.m00_axi_awvalid, axi.m00_axi_wvalid}, 64'd2);
    tick();
    checkOutput("c3_valids", {62'd0, axi.m00_axi_awvalid, axi.m00_axi_wvalid}, 64'd2);
    tick();
    axi.m00_axi_awready = 1'b1;
    #1;
    checkOutput("c4_awvalid", 64'(axi.m00_axi_awvalid), 64'd1);
    checkOutput("c4_bready", 64'(axi.m00_axi_bready), 64'd0);
    tick();
    axi.m00_axi_awready = 1'b0;
    checkOutput("c5_awvalid", 64'(axi.m00_axi_awvalid), 64'd0);
    checkOutput("c5_bready", 64'(axi.m00_axi_bready), 64'd1);
    axi.m00_axi_bvalid = 1'b1;
    tick();
    axi.m00_axi_bvalid = 1'b0;
    checkOutput("c6_rvalid_o", 64'(obi.data_rvalid_o), 64'd1);
    tick();

    // Error responses.
    $display("[TB] error responses");
    applyStimulus(32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    finishRead(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 2);
    applyStimulus(32'h0000_0104, 1'b1, 4'hC, 32'hA5A5_5A5A, 32'h0, 1'b1);
    finishWrite(32'h0000_0104, 32'hA5A5_5A5A, 4'hC, 2'b11);
    applyStimulus(32'h0000_0108, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0);
    finishWrite(32'h0000_0108, 32'h0BAD_F00D, 4'hF, 2'b00);

    // Backpressure: second request held while the bridge waits in RD_R.
    $display("[TB] backpressure");
    applyStimulus(32'h0000_0200, 1'b0, 4'hF, 32'h0, 32'h1111_2222, 1'b0);
    axi.m00_axi_arready = 1'b1;
    obi.data_req_i   = 1'b1;
    obi.data_addr_i  = 32'h0000_0044;
    obi.data_we_i    = 1'b1;
    obi.data_be_i    = 4'hF;
    obi.data_wdata_i = 32'h7777_8888;
    #1;
    checkOutput("bp_gnt_ar", 64'(obi.data_gnt_o), 64'd0);
    tick();
    axi.m00_axi_arready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_gnt_rd_r", 64'(obi.data_gnt_o), 64'd0);
      tick();
    end
    axi.m00_axi_rvalid = 1'b1;
    axi.m00_axi_rdata  = 32'h1111_2222;
    tick();
    axi.m00_axi_rvalid = 1'b0;
    axi.m00_axi_rdata  = '0;
    checkOutput("bp_gnt_resp", 64'(obi.data_gnt_o), 64'd0);
    checkOutput("bp_rvalid_o", 64'(obi.data_rvalid_o), 64'd1);
    tick();
    checkOutput("bp_gnt_idle", 64'(obi.data_gnt_o), 64'd1);
    sb.push_back({1'b0, 32'h0});
    tick();
    obi.data_req_i = 1'b0;
    finishWrite(32'h0000_0044, 32'h7777_8888, 4'hF, 2'b00);

    // Reset while waiting for B: outputs clear at once, transaction is lost.
    $display("[TB] reset mid-write");
    applyStimulus(32'h0000_0300, 1'b1, 4'h1, 32'hFEED_FACE, 32'h0, 1'b0);
    axi.m00_axi_awready = 1'b1;
    axi.m00_axi_wready  = 1'b1;
    tick();
    axi.m00_axi_awready = 1'b0;
    axi.m00_axi_wready  = 1'b0;
    checkOutput("mid_bready", 64'(axi.m00_axi_bready), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_outs", {58'd0, axi.m00_axi_awvalid, axi.m00_axi_wvalid,
                axi.m00_axi_arvalid, axi.m00_axi_bready, axi.m00_axi_rready,
                obi.data_rvalid_o}, 64'd0);
    checkOutput("async_rst_addr", 64'(axi.m00_axi_awaddr), 64'd0);
    sb.delete();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(32'h0000_0400, 1'b0, 4'hF, 32'h0, 32'h5555_AAAA, 1'b0);
    finishRead(32'h0000_0400, 32'h5555_AAAA, 2'b00, 1);

    // Stray B/R beats while idle are not acknowledged.
    $display("[TB] stray inputs");
    axi.m00_axi_bvalid = 1'b1;
    axi.m00_axi_rvalid = 1'b1;
    axi.m00_axi_rdata  = 32'hBADB_AD00;
    #1;
    checkOutput("stray_ready", {62'd0, axi.m00_axi_bready, axi.m00_axi_rready}, 64'd0);
    tick();
    tick();
    axi.m00_axi_bvalid = 1'b0;
    axi.m00_axi_rvalid = 1'b0;
    axi.m00_axi_rdata  = '0;
    checkOutput("stray_no_resp", 64'(obi.data_rvalid_o), 64'd0);
    applyStimulus(32'h0000_0500, 1'b0, 4'hF, 32'h0, 32'h0123_4567, 1'b0);
    finishRead(32'h0000_0500, 32'h0123_4567, 2'b00, 0);

    repeat (2) tick();
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
